// File: rtl/clic_regfile_pkg.sv
// Shared definitions for the CLIC configuration register bank.
// Holds the address map constants, the bit positions of every field inside a
// clicint word, the per-source field struct and the helper functions that
// pack, unpack and legalize a clicint word.
// Optional feature macro: CLIC_REGFILE_SHV_EN (when undefined, shv is
// hardwired to 0).
package clic_regfile_pkg;

  localparam logic [15:0] MCLIC_OFFSET = 16'h0000;
  localparam logic [15:0] CLICINT_BASE = 16'h1000;

  localparam int IP_BIT   = 0;
  localparam int IE_BIT   = 8;
  localparam int SHV_BIT  = 16;
  localparam int TRIG_LSB = 17;
  localparam int MODE_LSB = 22;
  localparam int CTL_LSB  = 24;

  // Only machine mode is implemented.
  localparam logic [1:0] MODE_M = 2'b11;

  typedef struct packed {
    logic [7:0] ctl;
    logic [1:0] mode;
    logic [1:0] trig;
    logic       shv;
    logic       ie;
    logic       ip;
  } clicint_fields_t;

  // Unimplemented low bits of ctl, which always read as 1.
  function automatic logic [7:0] ctl_low_mask(input int intctlbits);
    logic [7:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) begin
      if (b < 8 - intctlbits) m[b] = 1'b1;
    end
    return m;
  endfunction

  function automatic clicint_fields_t unpack_clicint(input logic [31:0] w);
    clicint_fields_t f;
    f.ip   = w[IP_BIT];
    f.ie   = w[IE_BIT];
    f.shv  = w[SHV_BIT];
    f.trig = w[TRIG_LSB +: 2];
    f.mode = w[MODE_LSB +: 2];
    f.ctl  = w[CTL_LSB +: 8];
    return f;
  endfunction

  function automatic logic [31:0] pack_clicint(input clicint_fields_t f);
    logic [31:0] w;
    w = '0;
    w[IP_BIT]        = f.ip;
    w[IE_BIT]        = f.ie;
    w[SHV_BIT]       = f.shv;
    w[TRIG_LSB +: 2] = f.trig;
    w[MODE_LSB +: 2] = f.mode;
    w[CTL_LSB +: 8]  = f.ctl;
    return w;
  endfunction

  // WARL legalization of a written value: an unsupported mode encoding keeps
  // the existing mode, and the upper trig bit is always forced to 0.
  function automatic clicint_fields_t legalize_clicint(input clicint_fields_t cur,
                                                       input clicint_fields_t wr,
                                                       input int intctlbits);
    clicint_fields_t f;
    f         = wr;
    f.ctl     = wr.ctl | ctl_low_mask(intctlbits);
    f.trig[1] = 1'b0;
    f.mode    = (wr.mode == MODE_M) ? wr.mode : cur.mode;
`ifndef CLIC_REGFILE_SHV_EN
    f.shv     = 1'b0;
`endif
    return f;
  endfunction

endpackage

// File: rtl/clic_int_reg.sv
// One clicint register: the field flops of a single interrupt source.
// Applies byte enables and legalization to bus writes, and gives the
// hardware pending-bit update priority over a same-cycle bus write to ip.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   we               bus write strobe addressed to this source (already granted)
//   be, wdata        byte enables and write data of the bus write
//   hw_ip_en, hw_ip  hardware pending-bit update enable and value
//   fields           current register contents
// Optional feature macro: CLIC_REGFILE_SHV_EN.
module clic_int_reg
  import clic_regfile_pkg::*;
#(
  parameter int INTCTLBITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [3:0]      be,
  input  logic [31:0]     wdata,
  input  logic            hw_ip_en,
  input  logic            hw_ip,
  output clicint_fields_t fields
);

  localparam clicint_fields_t RESET_VAL = '{
    ctl:  ctl_low_mask(INTCTLBITS),
    mode: MODE_M,
    trig: 2'b00,
    shv:  1'b0,
    ie:   1'b0,
    ip:   1'b0
  };

  clicint_fields_t q;
  clicint_fields_t d;
  clicint_fields_t legal;

  // Byte 2 carries shv, trig and mode together, so they share one enable.
  // The hardware ip update is applied last so it overrides the bus.
  always_comb begin
    legal = legalize_clicint(q, unpack_clicint(wdata), INTCTLBITS);
    d     = q;
    if (we) begin
      if (be[0]) d.ip = legal.ip;
      if (be[1]) d.ie = legal.ie;
      if (be[2]) begin
        d.shv  = legal.shv;
        d.trig = legal.trig;
        d.mode = legal.mode;
      end
      if (be[3]) d.ctl = legal.ctl;
    end
    if (hw_ip_en) d.ip = hw_ip;
`ifndef CLIC_REGFILE_SHV_EN
    d.shv = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) q <= RESET_VAL;
    else     q <= d;
  end

  always_comb begin
    fields = q;
`ifndef CLIC_REGFILE_SHV_EN
    fields.shv = 1'b0;
`endif
  end

endmodule

// File: rtl/clic_int_regfile.sv
// Bus-side register bank for the CLIC per-interrupt (clicint) and global
// (mclic) configuration registers.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_i, we_i, addr_i,   bus request: write flag, byte address,
//   wdata_i, be_i          write data and byte enables
//   gnt_o                  request accepted this cycle (combinational)
//   rvalid_o, rready_i     registered response handshake
//   rdata_o, err_o         response data (0 for writes/errors) and error flag
//   ip_de_i, ip_d_i        per-source hardware pending-bit update
//   intctl_o, intmode_o,   per-source configuration outputs (registered)
//   shv_o, trig_o, ie_o,
//   ip_o
//   mnxti_cfg_o            mclic mnxticonf bit
// Optional feature macro: CLIC_REGFILE_SHV_EN (per-source writable shv).
module clic_int_regfile
  import clic_regfile_pkg::*;
#(
  parameter int N_SOURCE   = 32,
  parameter int INTCTLBITS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [15:0]           addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            be_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  input  logic [N_SOURCE-1:0]   ip_de_i,
  input  logic [N_SOURCE-1:0]   ip_d_i,
  output logic [8*N_SOURCE-1:0] intctl_o,
  output logic [2*N_SOURCE-1:0] intmode_o,
  output logic [N_SOURCE-1:0]   shv_o,
  output logic [2*N_SOURCE-1:0] trig_o,
  output logic [N_SOURCE-1:0]   ie_o,
  output logic [N_SOURCE-1:0]   ip_o,
  output logic                  mnxti_cfg_o
);

  localparam logic [13:0] N_WORDS = 14'(N_SOURCE);

  logic            aligned;
  logic            hit_mclic;
  logic            hit_int;
  logic            dec_err;
  logic [13:0]     word_idx;
  logic [N_SOURCE-1:0] int_we;
  clicint_fields_t fields [N_SOURCE];
  logic [31:0]     int_rdata;
  logic [31:0]     rd_word;
  logic            mnxti_q;

  // A new request is accepted whenever the response slot is free or is
  // being drained in this same cycle.
  assign gnt_o = req_i & (~rvalid_o | rready_i);

  assign aligned   = (addr_i[1:0] == 2'b00);
  assign word_idx  = addr_i[15:2] - CLICINT_BASE[15:2];
  assign hit_mclic = aligned && (addr_i == MCLIC_OFFSET);
  assign hit_int   = aligned && (addr_i[15:2] >= CLICINT_BASE[15:2]) && (word_idx < N_WORDS);
  assign dec_err   = ~(hit_mclic | hit_int);

  for (genvar i = 0; i < N_SOURCE; i++) begin : g_src
    assign int_we[i] = gnt_o & we_i & hit_int & (word_idx == 14'(i));

    clic_int_reg #(
      .INTCTLBITS(INTCTLBITS)
    ) u_reg (
      .clk      (clk_i),
      .rst      (rst_i),
      .we       (int_we[i]),
      .be       (be_i),
      .wdata    (wdata_i),
      .hw_ip_en (ip_de_i[i]),
      .hw_ip    (ip_d_i[i]),
      .fields   (fields[i])
    );

    assign intctl_o[8*i +: 8]  = fields[i].ctl;
    assign intmode_o[2*i +: 2] = fields[i].mode;
    assign trig_o[2*i +: 2]    = fields[i].trig;
    assign shv_o[i]            = fields[i].shv;
    assign ie_o[i]             = fields[i].ie;
    assign ip_o[i]             = fields[i].ip;
  end

  // Read mux over the flop contents, so a read sees the state before any
  // same-cycle hardware ip update.
  always_comb begin
    int_rdata = '0;
    for (int i = 0; i < N_SOURCE; i++) begin
      if (word_idx == 14'(i)) int_rdata = pack_clicint(fields[i]);
    end
  end

  always_comb begin
    rd_word = '0;
    if (hit_mclic)    rd_word[0] = mnxti_q;
    else if (hit_int) rd_word    = int_rdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mnxti_q <= 1'b0;
    end else if (gnt_o && we_i && hit_mclic && be_i[0]) begin
      mnxti_q <= wdata_i[0];
    end
  end

  assign mnxti_cfg_o = mnxti_q;

  // Response register: loaded on grant, held until consumed, dropped on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else if (gnt_o) begin
      rvalid_o <= 1'b1;
      err_o    <= dec_err;
      rdata_o  <= (we_i || dec_err) ? 32'h0 : rd_word;
    end else if (rready_i) begin
      rvalid_o <= 1'b0;
      err_o    <= 1'b0;
      rdata_o  <= '0;
    end
  end

endmodule

// File: tb/tb_clic_int_regfile.sv
// Self-checking bench for clic_int_regfile (N_SOURCE=8, INTCTLBITS=4).
// Expected responses are queued when a request is granted and compared by a
// response monitor when the handshake completes; each scenario task also
// checks configuration outputs and handshake signals inline.
module tb_clic_int_regfile;

  localparam int N_SOURCE   = 8;
  localparam int INTCTLBITS = 4;
`ifdef CLIC_REGFILE_SHV_EN
  localparam bit SHV_EN = 1'b1;
`else
  localparam bit SHV_EN = 1'b0;
`endif

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  req_i;
  logic                  we_i;
  logic [15:0]           addr_i;
  logic [31:0]           wdata_i;
  logic [3:0]            be_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic                  rready_i;
  logic [31:0]           rdata_o;
  logic                  err_o;
  logic [N_SOURCE-1:0]   ip_de_i;
  logic [N_SOURCE-1:0]   ip_d_i;
  logic [8*N_SOURCE-1:0] intctl_o;
  logic [2*N_SOURCE-1:0] intmode_o;
  logic [N_SOURCE-1:0]   shv_o;
  logic [2*N_SOURCE-1:0] trig_o;
  logic [N_SOURCE-1:0]   ie_o;
  logic [N_SOURCE-1:0]   ip_o;
  logic                  mnxti_cfg_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_rdata_q[$];
  logic        exp_err_q[$];
  logic [31:0] mon_rdata;
  logic        mon_err;

  always #5 clk_i = ~clk_i;

  clic_int_regfile #(
    .N_SOURCE   (N_SOURCE),
    .INTCTLBITS (INTCTLBITS)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .be_i        (be_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rready_i    (rready_i),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .ip_de_i     (ip_de_i),
    .ip_d_i      (ip_d_i),
    .intctl_o    (intctl_o),
    .intmode_o   (intmode_o),
    .shv_o       (shv_o),
    .trig_o      (trig_o),
    .ie_o        (ie_o),
    .ip_o        (ip_o),
    .mnxti_cfg_o (mnxti_cfg_o)
  );

  // Response monitor: every completed handshake is compared with the oldest
  // queued expectation.
  always @(negedge clk_i) begin
    if (!rst_i && rvalid_o && rready_i) begin
      checks++;
      if (exp_rdata_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL resp_unexpected: got rdata=%h err=%b, required no response", rdata_o, err_o);
      end else begin
        mon_rdata = exp_rdata_q.pop_front();
        mon_err   = exp_err_q.pop_front();
        if (rdata_o !== mon_rdata || err_o !== mon_err) begin
          errors++;
          $display("[TB] FAIL resp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                   rdata_o, err_o, mon_rdata, mon_err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Issue one request (called just after a rising edge), wait for grant and
  // queue the expected response.
  task automatic bus_req(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    bit granted = 1'b0;
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
    for (int n = 0; n < 20 && !granted; n++) begin
      @(negedge clk_i);
      if (gnt_o === 1'b1) begin
        granted = 1'b1;
        exp_rdata_q.push_back(exp_rdata);
        exp_err_q.push_back(exp_err);
      end
      @(posedge clk_i); #1;
    end
    req_i = 1'b0; we_i = 1'b0;
    checks++;
    if (!granted) begin
      errors++;
      $display("[TB] FAIL grant_timeout: got no grant for addr %h, required grant", addr);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
    rready_i = 1'b1; ip_de_i = '0; ip_d_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (rvalid_o !== 1'b0 || err_o !== 1'b0 || gnt_o !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_bus: got rvalid=%b err=%b gnt=%b, required 0 0 0", rvalid_o, err_o, gnt_o); end
    checks++; if (rdata_o !== 32'h0) begin errors++;
      $display("[TB] FAIL reset_rdata: got %h, required 0", rdata_o); end
    checks++; if (intctl_o !== {N_SOURCE{8'h0F}}) begin errors++;
      $display("[TB] FAIL reset_ctl: got %h, required %h", intctl_o, {N_SOURCE{8'h0F}}); end
    checks++; if (intmode_o !== {(2*N_SOURCE){1'b1}}) begin errors++;
      $display("[TB] FAIL reset_mode: got %h, required all ones", intmode_o); end
    checks++; if (ie_o !== '0 || ip_o !== '0 || shv_o !== '0 || trig_o !== '0 || mnxti_cfg_o !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_fields: got ie=%h ip=%h shv=%h trig=%h mnxti=%b, required all 0",
               ie_o, ip_o, shv_o, trig_o, mnxti_cfg_o); end
    @(posedge clk_i); #1;
    bus_req(1'b0, 16'h1000, 32'h0, 4'h0, 32'h0FC0_0000, 1'b0);
  endtask

  task automatic test_write_legalize();
    bus_req(1'b1, 16'h1004, 32'hA5C7_0101, 4'hF, 32'h0, 1'b0);
    bus_req(1'b0, 16'h1004, 32'h0, 4'h0, SHV_EN ? 32'hAFC3_0101 : 32'hAFC2_0101, 1'b0);
    @(negedge clk_i);
    checks++; if (ie_o[1] !== 1'b1 || ip_o[1] !== 1'b1) begin errors++;
      $display("[TB] FAIL wr_ie_ip: got ie=%b ip=%b, required 1 1", ie_o[1], ip_o[1]); end
    checks++; if (intctl_o[15:8] !== 8'hAF) begin errors++;
      $display("[TB] FAIL wr_ctl: got %h, required af", intctl_o[15:8]); end
    checks++; if (trig_o[3:2] !== 2'b01 || shv_o[1] !== SHV_EN) begin errors++;
      $display("[TB] FAIL wr_trig_shv: got trig=%b shv=%b, required 01 %b", trig_o[3:2], shv_o[1], SHV_EN); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_mode();
    bus_req(1'b1, 16'h1000, 32'h0040_0000, 4'h4, 32'h0, 1'b0);
    bus_req(1'b0, 16'h1000, 32'h0, 4'h0, 32'h0FC0_0000, 1'b0);
    @(negedge clk_i);
    checks++; if (intmode_o[1:0] !== 2'b11) begin errors++;
      $display("[TB] FAIL mode_warl: got %b, required 11", intmode_o[1:0]); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_ip_priority();
    ip_de_i[2] = 1'b1; ip_d_i[2] = 1'b0;
    bus_req(1'b1, 16'h1008, 32'h0000_0101, 4'h3, 32'h0, 1'b0);
    ip_de_i = '0; ip_d_i = '0;
    @(negedge clk_i);
    checks++; if (ip_o[2] !== 1'b0 || ie_o[2] !== 1'b1) begin errors++;
      $display("[TB] FAIL ip_race: got ip=%b ie=%b, required 0 1", ip_o[2], ie_o[2]); end
    @(posedge clk_i); #1;
    ip_de_i[3] = 1'b1; ip_d_i[3] = 1'b1;
    @(posedge clk_i); #1;
    ip_de_i = '0; ip_d_i = '0;
    @(negedge clk_i);
    checks++; if (ip_o[3] !== 1'b1) begin errors++;
      $display("[TB] FAIL ip_hw_set: got %b, required 1", ip_o[3]); end
    @(posedge clk_i); #1;
    ip_de_i[3] = 1'b1; ip_d_i[3] = 1'b0;
    bus_req(1'b0, 16'h100C, 32'h0, 4'h0, 32'h0FC0_0001, 1'b0);
    ip_de_i = '0;
    @(negedge clk_i);
    checks++; if (ip_o[3] !== 1'b0) begin errors++;
      $display("[TB] FAIL ip_hw_clr: got %b, required 0", ip_o[3]); end
    @(posedge clk_i); #1;
    bus_req(1'b0, 16'h1008, 32'h0, 4'h0, 32'h0FC0_0100, 1'b0);
  endtask

  task automatic test_byte_enables();
    bus_req(1'b1, 16'h1014, 32'hFFFF_FFFF, 4'h2, 32'h0, 1'b0);
    bus_req(1'b1, 16'h1018, 32'h3000_0000, 4'h8, 32'h0, 1'b0);
    bus_req(1'b0, 16'h1014, 32'h0, 4'h0, 32'h0FC0_0100, 1'b0);
    bus_req(1'b0, 16'h1018, 32'h0, 4'h0, 32'h3FC0_0000, 1'b0);
    @(negedge clk_i);
    checks++; if (intctl_o[55:48] !== 8'h3F || ie_o[5] !== 1'b1 || ip_o[5] !== 1'b0) begin errors++;
      $display("[TB] FAIL byte_en: got ctl6=%h ie5=%b ip5=%b, required 3f 1 0", intctl_o[55:48], ie_o[5], ip_o[5]); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_mclic_and_errors();
    bus_req(1'b1, 16'h0000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0);
    bus_req(1'b0, 16'h0000, 32'h0, 4'h0, 32'h0000_0001, 1'b0);
    bus_req(1'b1, 16'h0001, 32'h0, 4'hF, 32'h0, 1'b1);
    bus_req(1'b1, 16'h1005, 32'h0, 4'hF, 32'h0, 1'b1);
    bus_req(1'b0, 16'h1002, 32'h0, 4'h0, 32'h0, 1'b1);
    bus_req(1'b0, 16'h1000 + 16'(4 * N_SOURCE), 32'h0, 4'h0, 32'h0, 1'b1);
    bus_req(1'b0, 16'h0FFC, 32'h0, 4'h0, 32'h0, 1'b1);
    bus_req(1'b0, 16'h1004, 32'h0, 4'h0, SHV_EN ? 32'hAFC3_0101 : 32'hAFC2_0101, 1'b0);
    @(negedge clk_i);
    checks++; if (mnxti_cfg_o !== 1'b1) begin errors++;
      $display("[TB] FAIL mnxti: got %b, required 1", mnxti_cfg_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back();
    time t0;
    t0 = $time;
    bus_req(1'b0, 16'h1000, 32'h0, 4'h0, 32'h0FC0_0000, 1'b0);
    bus_req(1'b0, 16'h1014, 32'h0, 4'h0, 32'h0FC0_0100, 1'b0);
    bus_req(1'b0, 16'h0000, 32'h0, 4'h0, 32'h0000_0001, 1'b0);
    checks++; if ($time - t0 != 30) begin errors++;
      $display("[TB] FAIL b2b_rate: got %0t time units for 3 grants, required 30", $time - t0); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_handshake();
    rready_i = 1'b0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 16'h1018; wdata_i = '0; be_i = '0;
    @(negedge clk_i);
    checks++; if (gnt_o !== 1'b1) begin errors++;
      $display("[TB] FAIL hs_first_gnt: got %b, required 1", gnt_o); end
    exp_rdata_q.push_back(32'h3FC0_0000); exp_err_q.push_back(1'b0);
    @(posedge clk_i); #1;
    addr_i = 16'h1014;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      checks++; if (gnt_o !== 1'b0 || rvalid_o !== 1'b1 || rdata_o !== 32'h3FC0_0000) begin errors++;
        $display("[TB] FAIL hs_stall: got gnt=%b rvalid=%b rdata=%h, required 0 1 3fc00000",
                 gnt_o, rvalid_o, rdata_o); end
      @(posedge clk_i); #1;
    end
    rready_i = 1'b1;
    @(negedge clk_i);
    checks++; if (gnt_o !== 1'b1) begin errors++;
      $display("[TB] FAIL hs_second_gnt: got %b, required 1", gnt_o); end
    exp_rdata_q.push_back(32'h0FC0_0100); exp_err_q.push_back(1'b0);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(negedge clk_i);
    checks++; if (rvalid_o !== 1'b1) begin errors++;
      $display("[TB] FAIL hs_second_resp: got rvalid=%b, required 1", rvalid_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid();
    rready_i = 1'b0;
    bus_req(1'b0, 16'h1004, 32'h0, 4'h0, 32'h0, 1'b0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_rdata_q.delete(); exp_err_q.delete();
    @(negedge clk_i);
    checks++; if (rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin errors++;
      $display("[TB] FAIL rst_mid_resp: got rvalid=%b rdata=%h, required 0 0", rvalid_o, rdata_o); end
    checks++; if (ie_o !== '0 || ip_o !== '0 || mnxti_cfg_o !== 1'b0 || intctl_o !== {N_SOURCE{8'h0F}}) begin errors++;
      $display("[TB] FAIL rst_mid_state: got ie=%h ip=%h mnxti=%b ctl=%h, required reset values",
               ie_o, ip_o, mnxti_cfg_o, intctl_o); end
    @(posedge clk_i); #1;
    rready_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write_legalize();
    test_mode();
    test_ip_priority();
    test_byte_enables();
    test_mclic_and_errors();
    test_back_to_back();
    test_handshake();
    test_reset_mid();
    repeat (3) @(posedge clk_i);
    checks++;
    if (exp_rdata_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL resp_missing: got %0d outstanding responses, required 0", exp_rdata_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
